// File: rtl/fpu_addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// fpu_addsub_arbiter_if : requester, response and fsub-unit signals of the
// shared add/subtract arbiter.  Rev 1.0
// ============================================================================
interface fpu_addsub_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_sub;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_y;
  logic [31:0]          fpu_x1;
  logic [31:0]          fpu_x2;
  logic [31:0]          fpu_y;
  logic                 busy;

  modport slave (
    input  req_valid, req_sub, req_x1, req_x2, fpu_y,
    output req_ready, resp_valid, resp_y, fpu_x1, fpu_x2, busy
  );

  modport master (
    output req_valid, req_sub, req_x1, req_x2, fpu_y,
    input  req_ready, resp_valid, resp_y, fpu_x1, fpu_x2, busy
  );
endinterface
`default_nettype wire

// File: rtl/fpu_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_addsub_arbiter : round-robin sharing of one pipelined fsub unit; add is
// issued as a subtract with the sign of x2 flipped.  Option: FPU_ARB_STATS_EN
// Rev 1.0
// ============================================================================
module fpu_addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 4,
  parameter int IDW  = 3
) (
  input  wire                  clk,
  input  wire                  rstn,
  fpu_addsub_arbiter_if.slave  bus
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]   grant_cnt
`endif
);

  logic [IDW-1:0]  r_ptr;
  logic            r_iss_v;
  logic [IDW-1:0]  r_iss_tag;
  logic [31:0]     r_x1;
  logic [31:0]     r_x2;
  logic [LAT-1:0]  r_pipe_v;
  logic [IDW-1:0]  r_pipe_tag [LAT];
  logic [NREQ-1:0] r_resp_valid;
  logic [31:0]     r_resp_y;

  logic            w_hi_any;
  logic            w_lo_any;
  logic            w_any;
  logic [IDW-1:0]  w_hi_sel;
  logic [IDW-1:0]  w_lo_sel;
  logic [IDW-1:0]  w_sel;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_tail_oh;
  logic [31:0]     w_x1;
  logic [31:0]     w_x2;
  logic            w_sub;

  // Lowest valid index above the pointer wins; otherwise wrap to lowest valid.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_sel = '0;
    w_lo_any = 1'b0;
    w_lo_sel = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j]) begin
        w_lo_any = 1'b1;
        w_lo_sel = IDW'(j);
        if (IDW'(j) > r_ptr) begin
          w_hi_any = 1'b1;
          w_hi_sel = IDW'(j);
        end
      end
    end
    w_any = w_lo_any & rstn;
    w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
  end

  always_comb begin
    w_ready   = '0;
    w_x1      = '0;
    w_x2      = '0;
    w_sub     = 1'b0;
    w_tail_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_sel == IDW'(j)) begin
        w_ready[j] = w_any;
        w_x1       = bus.req_x1[32*j +: 32];
        w_x2       = bus.req_x2[32*j +: 32];
        w_sub      = bus.req_sub[j];
      end
      if (r_pipe_tag[LAT-1] == IDW'(j)) begin
        w_tail_oh[j] = r_pipe_v[LAT-1];
      end
    end
  end

  // Operand registers only load on accept so the unit inputs stay quiet when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr     <= IDW'(NREQ - 1);
      r_iss_v   <= 1'b0;
      r_iss_tag <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
    end else begin
      r_iss_v <= w_any;
      if (w_any) begin
        r_ptr     <= w_sel;
        r_iss_tag <= w_sel;
        r_x1      <= w_x1;
        r_x2      <= w_sub ? w_x2 : {~w_x2[31], w_x2[30:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipe_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_pipe_tag[k] <= '0;
      end
    end else begin
      r_pipe_v[0]   <= r_iss_v;
      r_pipe_tag[0] <= r_iss_tag;
      for (int k = 1; k < LAT; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_tag[k] <= r_pipe_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= '0;
      r_resp_y     <= '0;
    end else begin
      r_resp_valid <= w_tail_oh;
      if (r_pipe_v[LAT-1]) begin
        r_resp_y <= bus.fpu_y;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_y     = r_resp_y;
  assign bus.fpu_x1     = r_x1;
  assign bus.fpu_x2     = r_x2;
  assign bus.busy       = r_iss_v | (|r_pipe_v) | (|r_resp_valid);

`ifdef FPU_ARB_STATS_EN
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (w_ready[g] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign grant_cnt[16*g +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_arbiter.sv
`default_nettype none
// tb_fpu_addsub_arbiter : directed and randomized checks of the arbiter against
// a real-valued arithmetic model, the round-robin rule and a response queue.
`timescale 1ns/1ps
module tb_fpu_addsub_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef FPU_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt;
`endif

  fpu_addsub_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef FPU_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- float helpers (normal range, denormals flushed) ----------
  function automatic real to_real(logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_bits(real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'd0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    e = e - 1023 + 127;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  // ---------------- attached 4-stage subtract unit --------------------------
  logic [31:0] u_s [LAT];
  always @(posedge clk) begin
    u_s[0] <= to_bits(to_real(bus.fpu_x1) - to_real(bus.fpu_x2));
    for (int k = 1; k < LAT; k++) u_s[k] <= u_s[k-1];
  end
  assign bus.fpu_y = u_s[LAT-1];

  // ---------------- reference model state ----------------------------------
  typedef struct {
    logic [NREQ-1:0] oh;
    logic [31:0]     y;
    int              due;
  } exp_t;

  int              n_vec = 0;
  int              n_err = 0;
  int              cyc   = 0;
  int              last_gnt;
  int              m_cnt [NREQ];
  logic [31:0]     m_x1, m_x2, m_y;
  exp_t            expq [$];
  logic [NREQ-1:0] s_v, s_sub;
  logic [32*NREQ-1:0] s_x1, s_x2;

  int          t_id  [3] = '{0, 1, 0};
  logic        t_sub [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] t_x1  [3] = '{32'h40400000, 32'h3F800000, 32'h3F800000};
  logic [31:0] t_x2  [3] = '{32'h3F800000, 32'h40000000, 32'hBF800000};
  logic [31:0] t_fx2 [3] = '{32'h3F800000, 32'hC0000000, 32'h3F800000};
  logic [31:0] t_y   [3] = '{32'h40000000, 32'h40400000, 32'h00000000};

  task automatic model_reset();
    last_gnt = NREQ - 1;
    m_x1 = '0;
    m_x2 = '0;
    m_y  = '0;
    expq.delete();
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [NREQ-1:0] model_ready(logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last_gnt + k) % NREQ;
      if (((v >> i) & NREQ'(1)) != '0) return NREQ'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_accept(logic [NREQ-1:0] rdy);
    logic [31:0] x1, x2;
    logic        sub;
    exp_t        e;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy == (NREQ'(1) << i)) begin
        x1  = 32'(s_x1 >> (32 * i));
        x2  = 32'(s_x2 >> (32 * i));
        sub = ((s_sub >> i) & NREQ'(1)) != '0;
        m_x1 = x1;
        m_x2 = sub ? x2 : {~x2[31], x2[30:0]};
        e.oh  = rdy;
        e.y   = sub ? to_bits(to_real(x1) - to_real(x2)) : to_bits(to_real(x1) + to_real(x2));
        e.due = cyc + LAT + 2;
        expq.push_back(e);
        last_gnt = i;
        if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic model_resp(output logic [NREQ-1:0] erv, output logic ebusy);
    ebusy = (expq.size() != 0);
    erv   = '0;
    if (expq.size() != 0 && expq[0].due == cyc) begin
      erv = expq[0].oh;
      m_y = expq[0].y;
      void'(expq.pop_front());
    end
  endtask

  task automatic drive();
    bus.req_valid = s_v;
    bus.req_sub   = s_sub;
    bus.req_x1    = s_x1;
    bus.req_x2    = s_x2;
  endtask

  task automatic rnd_stim(logic [NREQ-1:0] v);
    s_v = v;
    for (int i = 0; i < NREQ; i++) begin
      s_sub[i]         = 1'($urandom);
      s_x1[32*i +: 32] = rnd_op();
      s_x2[32*i +: 32] = rnd_op();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    s_v = '1; s_sub = '0; s_x1 = '0; s_x2 = '0;
    drive();
    model_reset();
    tick();
    n_vec++;
    if (bus.req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready got=%b want=0", bus.req_ready);
    end
    n_vec++;
    if (bus.resp_valid !== '0 || bus.resp_y !== 32'd0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_resp resp_valid=%b resp_y=%h busy=%b want 0", bus.resp_valid, bus.resp_y, bus.busy);
    end
    n_vec++;
    if (bus.fpu_x1 !== 32'd0 || bus.fpu_x2 !== 32'd0) begin
      n_err++; $display("FAIL reset_fpu fpu_x1=%h fpu_x2=%h want 0", bus.fpu_x1, bus.fpu_x2);
    end
`ifdef FPU_ARB_STATS_EN
    n_vec++;
    if (grant_cnt !== '0) begin
      n_err++; $display("FAIL reset_cnt got=%h want=0", grant_cnt);
    end
`endif
    s_v = '0;
    drive();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] erdy, erv;
    logic            ebusy;
    for (int c = 0; c < 12; c++) begin
      rnd_stim((c < 4) ? '1 : '0);
      drive();
      #1;
      erdy = model_ready(s_v);
      n_vec++;
      if (bus.req_ready !== erdy) begin
        n_err++; $display("FAIL contention_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, erdy);
      end
      model_accept(erdy);
      tick();
      model_resp(erv, ebusy);
      n_vec++;
      if (bus.resp_valid !== erv || bus.resp_y !== m_y || bus.busy !== ebusy ||
          bus.fpu_x1 !== m_x1 || bus.fpu_x2 !== m_x2) begin
        n_err++;
        $display("FAIL contention_resp cyc=%0d resp_valid=%b/%b resp_y=%h/%h busy=%b/%b fpu_x1=%h/%h fpu_x2=%h/%h",
                 cyc, bus.resp_valid, erv, bus.resp_y, m_y, bus.busy, ebusy, bus.fpu_x1, m_x1, bus.fpu_x2, m_x2);
      end
    end
  endtask

  task automatic test_directed();
    logic [NREQ-1:0] erdy, erv;
    logic            ebusy;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 8; c++) begin
        s_v = '0; s_sub = '0; s_x1 = '0; s_x2 = '0;
        if (c == 0) begin
          s_v[t_id[t]]             = 1'b1;
          s_sub[t_id[t]]           = t_sub[t];
          s_x1[32*t_id[t] +: 32]   = t_x1[t];
          s_x2[32*t_id[t] +: 32]   = t_x2[t];
        end
        drive();
        #1;
        erdy = model_ready(s_v);
        n_vec++;
        if (bus.req_ready !== erdy) begin
          n_err++; $display("FAIL directed%0d_ready got=%b want=%b", t, bus.req_ready, erdy);
        end
        model_accept(erdy);
        tick();
        if (c == 0) begin
          n_vec++;
          if (bus.fpu_x2 !== t_fx2[t] || bus.fpu_x1 !== t_x1[t]) begin
            n_err++; $display("FAIL directed%0d_issue fpu_x1=%h/%h fpu_x2=%h/%h", t, bus.fpu_x1, t_x1[t], bus.fpu_x2, t_fx2[t]);
          end
        end
        model_resp(erv, ebusy);
        n_vec++;
        if (bus.resp_valid !== erv || bus.resp_y !== m_y || bus.busy !== ebusy ||
            bus.fpu_x1 !== m_x1 || bus.fpu_x2 !== m_x2) begin
          n_err++;
          $display("FAIL directed%0d_resp cyc=%0d resp_valid=%b/%b resp_y=%h/%h busy=%b/%b",
                   t, cyc, bus.resp_valid, erv, bus.resp_y, m_y, bus.busy, ebusy);
        end
        if (c == 5) begin
          n_vec++;
          if (bus.resp_valid !== (NREQ'(1) << t_id[t]) || bus.resp_y !== t_y[t]) begin
            n_err++; $display("FAIL directed%0d_result resp_valid=%b resp_y=%h want resp_y=%h", t, bus.resp_valid, bus.resp_y, t_y[t]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] erdy, erv;
    logic            ebusy;
    int              pulses;
    pulses = 0;
    for (int c = 0; c < 18; c++) begin
      rnd_stim((c < 10) ? NREQ'(1) : '0);
      drive();
      #1;
      erdy = model_ready(s_v);
      n_vec++;
      if (bus.req_ready !== erdy) begin
        n_err++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, erdy);
      end
      model_accept(erdy);
      tick();
      if (bus.resp_valid != '0) pulses++;
      model_resp(erv, ebusy);
      n_vec++;
      if (bus.resp_valid !== erv || bus.resp_y !== m_y || bus.busy !== ebusy ||
          bus.fpu_x1 !== m_x1 || bus.fpu_x2 !== m_x2) begin
        n_err++;
        $display("FAIL b2b_resp cyc=%0d resp_valid=%b/%b resp_y=%h/%h busy=%b/%b",
                 cyc, bus.resp_valid, erv, bus.resp_y, m_y, bus.busy, ebusy);
      end
    end
    n_vec++;
    if (pulses != 10 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_count pulses=%0d want=10 busy=%b want=0", pulses, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] erdy, erv;
    logic            ebusy;
    for (int c = 0; c < 90; c++) begin
      rnd_stim((c < 80) ? NREQ'($urandom) : '0);
      drive();
      #1;
      erdy = model_ready(s_v);
      n_vec++;
      if (bus.req_ready !== erdy) begin
        n_err++; $display("FAIL random_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, erdy);
      end
      model_accept(erdy);
      tick();
      model_resp(erv, ebusy);
      n_vec++;
      if (bus.resp_valid !== erv || bus.resp_y !== m_y || bus.busy !== ebusy ||
          bus.fpu_x1 !== m_x1 || bus.fpu_x2 !== m_x2) begin
        n_err++;
        $display("FAIL random_resp cyc=%0d resp_valid=%b/%b resp_y=%h/%h busy=%b/%b fpu_x1=%h/%h fpu_x2=%h/%h",
                 cyc, bus.resp_valid, erv, bus.resp_y, m_y, bus.busy, ebusy, bus.fpu_x1, m_x1, bus.fpu_x2, m_x2);
      end
    end
`ifdef FPU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      n_vec++;
      if (int'(grant_cnt[16*i +: 16]) != m_cnt[i]) begin
        n_err++; $display("FAIL random_cnt%0d got=%0d want=%0d", i, grant_cnt[16*i +: 16], m_cnt[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_midflight();
    logic [NREQ-1:0] erdy, erv;
    logic            ebusy;
    for (int c = 0; c < 3; c++) begin
      rnd_stim(NREQ'(1));
      drive();
      #1;
      erdy = model_ready(s_v);
      n_vec++;
      if (bus.req_ready !== erdy) begin
        n_err++; $display("FAIL midrst_ready got=%b want=%b", bus.req_ready, erdy);
      end
      model_accept(erdy);
      tick();
    end
    rstn = 1'b0;
    #1;
    n_vec++;
    if (bus.resp_valid !== '0 || bus.resp_y !== 32'd0 || bus.busy !== 1'b0 ||
        bus.fpu_x1 !== 32'd0 || bus.fpu_x2 !== 32'd0 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL midrst_async resp_valid=%b resp_y=%h busy=%b fpu_x1=%h fpu_x2=%h ready=%b want all 0",
               bus.resp_valid, bus.resp_y, bus.busy, bus.fpu_x1, bus.fpu_x2, bus.req_ready);
    end
`ifdef FPU_ARB_STATS_EN
    n_vec++;
    if (grant_cnt !== '0) begin
      n_err++; $display("FAIL midrst_cnt got=%h want=0", grant_cnt);
    end
`endif
    model_reset();
    s_v = '0;
    drive();
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rnd_stim((c == 0) ? '1 : '0);
      drive();
      #1;
      erdy = model_ready(s_v);
      n_vec++;
      if (bus.req_ready !== erdy) begin
        n_err++; $display("FAIL midrst_ptr cyc=%0d got=%b want=%b", cyc, bus.req_ready, erdy);
      end
      model_accept(erdy);
      tick();
      model_resp(erv, ebusy);
      n_vec++;
      if (bus.resp_valid !== erv || bus.resp_y !== m_y || bus.busy !== ebusy ||
          bus.fpu_x1 !== m_x1 || bus.fpu_x2 !== m_x2) begin
        n_err++;
        $display("FAIL midrst_resp cyc=%0d resp_valid=%b/%b resp_y=%h/%h busy=%b/%b",
                 cyc, bus.resp_valid, erv, bus.resp_y, m_y, bus.busy, ebusy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
Shares one pipelined single-precision subtract unit (fsub, 4 register stages, no stall, no valid) between NREQ requesters, each issuing add or subtract operations.
- Round-robin arbitration, one issue per cycle.
- Add is converted to subtract by inverting the sign of x2.
- A requester-ID/valid shift register runs alongside the unit's pipeline, and each result is returned to the requester that issued it.
- Sits between the core's FP issue logic (ALU-side and any auxiliary requester) and the single fsub instance.

Parameters:
NREQ, 2, number of requesters (2..8)
LAT, 4, register stages inside the attached subtract unit (fixed by the unit; must match it)
IDW, 3, width of internal requester-ID tag (must satisfy 2**IDW >= NREQ)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester grant (one-hot or zero)
req_sub  in  NREQ  1 = x1-x2, 0 = x1+x2
req_x1  in  32*NREQ  operand 1, requester i at bits [32i+31:32i]
req_x2  in  32*NREQ  operand 2, same packing
resp_valid  out  NREQ  one-cycle pulse to the requester owning resp_y
resp_y  out  32  result
fpu_x1  out  32  to unit x1
fpu_x2  out  32  to unit x2
fpu_y  in  32  from unit y
busy  out  1  any operation in flight (issue register or valid pipe)

Behaviour:
- Reset (rstn low, asynchronous): req_ready=0, resp_valid=0, resp_y=0, fpu_x1=fpu_x2=0, busy=0, valid pipe cleared, RR pointer=NREQ-1 (requester 0 wins first).
- Arbitration (combinational):
  - Search starts at pointer+1 mod NREQ; the first i with req_valid[i] gets req_ready[i]=1.
  - At most one ready bit is high; all are zero when no request is valid.
  - req_ready does not depend on resp.
- Handshake: a transfer occurs on a rising edge where req_valid[i] && req_ready[i].
- On the accept edge:
  - Issue register captures x1 and x2'. x2' = req_sub ? x2 : {~x2[31], x2[30:0]}; the unit subtracts, so add requires the sign flip.
  - Tag register captures i and valid=1.
  - Pointer becomes i.
- Without an accept, the issue valid bit goes to 0 and the operand registers hold their values (no toggling).
- fpu_x1/fpu_x2 are driven directly from the issue registers.
- Tag/valid pipe is LAT deep and shifts every cycle; it never stalls, matching the unit.
- When the pipe tail is valid, the output stage registers resp_y<=fpu_y and resp_valid<=onehot(tag), else resp_valid<=0 and resp_y holds.
- Latency: resp_valid is high in the cycle after the (LAT+1)th rising edge following the accept edge (5 edges for LAT=4). Throughput is 1 op/cycle.
- Responses return in issue order. There is no response backpressure: the requester must sink resp in its pulse cycle.
- busy = issue valid OR any pipe valid OR resp_valid.
- Simultaneous events: a new accept on the same edge a result is emitted is legal. Any requester may re-request on the cycle after its grant.
- NREQ=1: always grants requester 0 when valid.
- Reset mid-operation: all in-flight tags are dropped; no resp_valid pulses appear after rstn deasserts for operations issued before reset.
- Arithmetic: results are exactly the unit's (round-to-nearest-even, denormals flushed as the unit does). The arbiter never modifies operands except the sign flip of x2.

Optional Feature:
FPU_ARB_STATS_EN:
- Defined: adds output port grant_cnt (16*NREQ bits), a saturating 16-bit accept counter per requester.
  - Reset to 0.
  - Increments on each accept.
  - Holds at 16'hFFFF.
- Undefined: port and counters absent; all other behaviour is identical.

Test Plan:
- Single op: requester 0, req_sub=1, x1=0x40400000 (3.0), x2=0x3F800000 (1.0), accepted at edge E → resp_valid=2'b01 after edge E+5, resp_y=0x40000000.
- Add path: requester 1, req_sub=0, x1=0x3F800000, x2=0x40000000 → fpu_x2=0xC0000000, resp_valid=2'b10, resp_y=0x40400000.
- Zero result: add 0x3F800000 + 0xBF800000 → resp_y=0x00000000.
- Contention: both requesters valid for 4 consecutive cycles → grants 0,1,0,1. Results come back tagged 01,10,01,10 in consecutive cycles, each 5 edges after its accept.
- Back-to-back: requester 0 valid for 10 cycles alone → 10 accepts, 10 consecutive resp pulses. busy stays high through the last pulse, then 0.
- Reset mid-flight: issue 3 ops, assert rstn low 2 cycles after the first accept, then release → outputs reset immediately; no resp_valid afterward. With FPU_ARB_STATS_EN the counters read 0.
